// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-granular scheduler that shares one UART transmitter
// between two word-wide requesters. Words are sent LSB byte first.
module uart_tx_scheduler #(
   parameter int unsigned len      = 32,
   parameter int unsigned LEN_DATA = 8,
   parameter int unsigned NB_BYTES = len / LEN_DATA,
   parameter int unsigned NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0_valid,
   input  logic [len-1:0]      req0_data,
   input  logic                req0_last,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [len-1:0]      req1_data,
   input  logic                req1_last,
   output logic                req1_ready,
   input  logic                tx_done,
   output logic                tx_start,
   output logic [LEN_DATA-1:0] uart_data_out,
   output logic [1:0]          grant,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t              r_state, w_state_nxt;
   logic [len-1:0]      r_shift, w_shift_nxt;
   logic [NB_CNT-1:0]   r_byte_cnt, w_byte_cnt_nxt;
   logic                r_last_q, w_last_q_nxt;
   logic                r_lock, w_lock_nxt;
   logic                r_rr_ptr, w_rr_ptr_nxt;
   logic                r_tx_start, w_tx_start_nxt;
   logic [LEN_DATA-1:0] r_data_out, w_data_out_nxt;
   logic [1:0]          r_grant, w_grant_nxt;

   logic                w_elig0, w_elig1;
   logic                w_win0, w_win1;
   logic [len-1:0]      w_sel_data;
   logic                w_sel_last;
   logic [len-1:0]      w_shift_dn;
   logic                w_last_byte;

   // Arbitration: a held lock restricts eligibility to the owner; ties go to rr_ptr.
   always_comb begin
      w_elig0    = req0_valid & (~r_lock | r_grant[0]);
      w_elig1    = req1_valid & (~r_lock | r_grant[1]);
      w_win0     = w_elig0 & (~w_elig1 | ~r_rr_ptr);
      w_win1     = w_elig1 & (~w_elig0 |  r_rr_ptr);
      w_sel_data = w_win1 ? req1_data : req0_data;
      w_sel_last = w_win1 ? req1_last : req0_last;
      w_shift_dn = r_shift >> LEN_DATA;
      w_last_byte = (r_byte_cnt == NB_CNT'(NB_BYTES - 1));
      req0_ready = (r_state == IDLE) & ~reset & w_win0;
      req1_ready = (r_state == IDLE) & ~reset & w_win1;
   end

   // Next-state and next-register values for the IDLE/SEND/GAP sequencer.
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_byte_cnt_nxt = r_byte_cnt;
      w_last_q_nxt   = r_last_q;
      w_lock_nxt     = r_lock;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_tx_start_nxt = r_tx_start;
      w_data_out_nxt = r_data_out;
      w_grant_nxt    = r_grant;
      case (r_state)
         IDLE: begin
            if (w_win0 | w_win1) begin
               w_shift_nxt    = w_sel_data;
               w_last_q_nxt   = w_sel_last;
               w_grant_nxt    = {w_win1, w_win0};
               w_byte_cnt_nxt = '0;
               w_tx_start_nxt = 1'b1;
               w_data_out_nxt = w_sel_data[LEN_DATA-1:0];
               w_state_nxt    = SEND;
            end
         end
         SEND: begin
            if (tx_done) begin
               w_tx_start_nxt = 1'b0;
               w_state_nxt    = GAP;
            end
         end
         GAP: begin
            if (!w_last_byte) begin
               w_byte_cnt_nxt = r_byte_cnt + NB_CNT'(1);
               w_shift_nxt    = w_shift_dn;
               w_data_out_nxt = w_shift_dn[LEN_DATA-1:0];
               w_tx_start_nxt = 1'b1;
               w_state_nxt    = SEND;
            end else begin
               if (r_last_q) begin
                  w_lock_nxt   = 1'b0;
                  w_grant_nxt  = '0;
                  w_rr_ptr_nxt = r_grant[0];
               end else begin
                  w_lock_nxt   = 1'b1;
               end
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_byte_cnt <= '0;
         r_last_q   <= 1'b0;
         r_lock     <= 1'b0;
         r_rr_ptr   <= 1'b0;
         r_tx_start <= 1'b0;
         r_data_out <= '0;
         r_grant    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_last_q   <= w_last_q_nxt;
         r_lock     <= w_lock_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_tx_start <= w_tx_start_nxt;
         r_data_out <= w_data_out_nxt;
         r_grant    <= w_grant_nxt;
      end
   end

   assign tx_start      = r_tx_start;
   assign uart_data_out = r_data_out;
   assign grant         = r_grant;
   assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: expected byte stream (byte, owner) is built
// from the words in the order arbitration must serve them.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_last, req0_ready;
   logic [31:0] req0_data;
   logic        req1_valid, req1_last, req1_ready;
   logic [31:0] req1_data;
   logic        tx_done, tx_start, busy;
   logic        resp_done, spur_done;
   logic [7:0]  uart_data_out;
   logic [1:0]  grant;

   assign tx_done = resp_done | spur_done;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.len(32), .LEN_DATA(8)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .tx_done(tx_done), .tx_start(tx_start), .uart_data_out(uart_data_out),
      .grant(grant), .busy(busy)
   );

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_byte_q[$];
   logic [1:0] exp_owner_q[$];
   logic [7:0] got_q[$];
   int n_rises = 0;
   int ready0_cycles = 0;
   logic prev_tx = 1'b0;
   logic [7:0] held_byte = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [1:0] owner, input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         exp_byte_q.push_back(8'(w >> (8 * i)));
         exp_owner_q.push_back(owner);
      end
   endtask

   // Compare process: each new tx_start must carry the next expected byte/owner.
   always @(negedge clk) begin
      logic [7:0] eb;
      logic [1:0] eo;
      #2;
      if (reset) begin
         prev_tx = tx_start;
      end else begin
         if (req0_ready) ready0_cycles++;
         if (req0_ready || req1_ready) begin
            check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
            check("ready_only_idle", {31'd0, busy}, 32'd0);
         end
         if (tx_start && !prev_tx) begin
            n_rises++;
            got_q.push_back(uart_data_out);
            held_byte = uart_data_out;
            if (exp_byte_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_tx_start: got byte %0h expected no transmission", uart_data_out);
            end else begin
               eb = exp_byte_q.pop_front();
               eo = exp_owner_q.pop_front();
               check("byte", {24'd0, uart_data_out}, {24'd0, eb});
               check("grant_during_byte", {30'd0, grant}, {30'd0, eo});
            end
         end else if (tx_start && prev_tx) begin
            check("byte_stable", {24'd0, uart_data_out}, {24'd0, held_byte});
         end
         prev_tx = tx_start;
      end
   end

   // UART model: tx_done pulses for one cycle 3 cycles after each tx_start rise.
   initial begin
      logic r_prev;
      r_prev = 1'b0;
      resp_done = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start && !r_prev) begin
            repeat (2) @(negedge clk);
            resp_done = 1'b1;
            @(negedge clk);
            resp_done = 1'b0;
         end
         r_prev = tx_start;
      end
   end

   task automatic drive(input int r, input logic [31:0] d, input logic l, output int waited);
      logic rdy;
      waited = 0;
      @(negedge clk);
      if (r == 0) begin req0_valid = 1'b1; req0_data = d; req0_last = l; end
      else        begin req1_valid = 1'b1; req1_data = d; req1_last = l; end
      #1;
      rdy = (r == 0) ? req0_ready : req1_ready;
      while (!rdy && waited < 3000) begin
         @(negedge clk);
         #1;
         waited++;
         rdy = (r == 0) ? req0_ready : req1_ready;
      end
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: requester %0d got no ready expected ready within 3000 cycles", r);
      end else begin
         @(posedge clk);
      end
      #1;
      if (r == 0) begin req0_valid = 1'b0; req0_data = ~d; req0_last = ~l; end
      else        begin req1_valid = 1'b0; req1_data = ~d; req1_last = ~l; end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_byte_q.size() != 0 || busy || tx_start) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("queue_drained", 32'(exp_byte_q.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_start", {31'd0, tx_start}, 32'd0);
      check("rst_data", {24'd0, uart_data_out}, 32'd0);
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wa, wb, base, n;
      reset = 1'b1;
      req0_valid = 1'b1; req0_data = 32'h11223344; req0_last = 1'b1;
      req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
      spur_done = 1'b0;

      // Reset state; ready must stay low even with a valid request.
      repeat (3) begin
         @(negedge clk);
         #1;
         check("ready0_in_reset", {31'd0, req0_ready}, 32'd0);
      end
      check("rst_tx_start", {31'd0, tx_start}, 32'd0);
      check("rst_data", {24'd0, uart_data_out}, 32'd0);
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      req0_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Single word from requester 0.
      push_word(2'b01, 32'h11223344);
      got_q.delete();
      ready0_cycles = 0;
      base = n_rises;
      drive(0, 32'h11223344, 1'b1, wa);
      check("lat1_tx_start", {31'd0, tx_start}, 32'd1);
      check("lat1_data", {24'd0, uart_data_out}, 32'h44);
      check("lat1_grant", {30'd0, grant}, 32'h1);
      check("lat1_busy", {31'd0, busy}, 32'd1);
      wait_idle();
      check("t1_rises", 32'(n_rises - base), 32'd4);
      if (got_q.size() == 4) begin
         check("t1_b0", {24'd0, got_q[0]}, 32'h44);
         check("t1_b1", {24'd0, got_q[1]}, 32'h33);
         check("t1_b2", {24'd0, got_q[2]}, 32'h22);
         check("t1_b3", {24'd0, got_q[3]}, 32'h11);
      end else begin
         check("t1_got_count", 32'(got_q.size()), 32'd4);
      end
      check("t1_ready0_cycles", 32'(ready0_cycles), 32'd1);
      check("t1_grant_end", {30'd0, grant}, 32'd0);

      // rr_ptr now points at requester 1: simultaneous requests serve req1 first.
      push_word(2'b10, 32'hD0D1D2D3);
      push_word(2'b01, 32'hC0C1C2C3);
      fork
         drive(0, 32'hC0C1C2C3, 1'b1, wa);
         drive(1, 32'hD0D1D2D3, 1'b1, wb);
      join
      wait_idle();

      // After reset requester 0 has priority; alternation over 4 packets.
      do_reset();
      push_word(2'b01, 32'hAAAAAAAA);
      push_word(2'b10, 32'h55555555);
      fork
         drive(0, 32'hAAAAAAAA, 1'b1, wa);
         drive(1, 32'h55555555, 1'b1, wb);
      join
      wait_idle();
      push_word(2'b01, 32'h01234567);
      push_word(2'b10, 32'h89ABCDEF);
      fork
         drive(0, 32'h01234567, 1'b1, wa);
         drive(1, 32'h89ABCDEF, 1'b1, wb);
      join
      wait_idle();

      // Three-word packet from req0 is not interleaved with a waiting req1.
      push_word(2'b01, 32'h10203040);
      push_word(2'b01, 32'h50607080);
      push_word(2'b01, 32'h90A0B0C0);
      push_word(2'b10, 32'h13579BDF);
      fork
         begin
            drive(0, 32'h10203040, 1'b0, wa);
            drive(0, 32'h50607080, 1'b0, wa);
            drive(0, 32'h90A0B0C0, 1'b1, wa);
         end
         drive(1, 32'h13579BDF, 1'b1, wb);
      join
      wait_idle();

      // Lock stall: owner idle for 20 cycles, req1 valid but blocked.
      push_word(2'b01, 32'h0A0B0C0D);
      push_word(2'b01, 32'h1A2B3C4D);
      push_word(2'b10, 32'h99887766);
      base = n_rises;
      fork
         drive(1, 32'h99887766, 1'b1, wb);
         begin
            drive(0, 32'h0A0B0C0D, 1'b0, wa);
            n = 0;
            while ((n_rises < base + 4 || busy || tx_start) && n < 2000) begin
               @(negedge clk);
               n++;
            end
            check("lock_word1_done", 32'(n_rises - base), 32'd4);
            repeat (20) begin
               @(negedge clk);
               #1;
               check("lock_tx_start", {31'd0, tx_start}, 32'd0);
               check("lock_grant", {30'd0, grant}, 32'h1);
               check("lock_busy", {31'd0, busy}, 32'd0);
               check("lock_ready1", {31'd0, req1_ready}, 32'd0);
            end
            drive(0, 32'h1A2B3C4D, 1'b1, wa);
         end
      join
      wait_idle();

      // Spurious tx_done in IDLE and in every GAP cycle.
      repeat (5) begin
         @(negedge clk);
         spur_done = 1'b1;
         @(negedge clk);
         spur_done = 1'b0;
         #1;
         check("spur_idle_busy", {31'd0, busy}, 32'd0);
         check("spur_idle_tx", {31'd0, tx_start}, 32'd0);
      end
      push_word(2'b01, 32'hCAFEF00D);
      base = n_rises;
      fork
         drive(0, 32'hCAFEF00D, 1'b1, wa);
         begin
            for (int g = 0; g < 4; g++) begin
               n = 0;
               @(negedge clk);
               while (!(busy && !tx_start) && n < 200) begin
                  @(negedge clk);
                  n++;
               end
               spur_done = 1'b1;
               @(negedge clk);
               spur_done = 1'b0;
            end
         end
      join
      wait_idle();
      check("spur_rises", 32'(n_rises - base), 32'd4);

      // Reset in the GAP after the 2nd byte of a non-last word.
      exp_byte_q.push_back(8'hEF); exp_owner_q.push_back(2'b01);
      exp_byte_q.push_back(8'hBE); exp_owner_q.push_back(2'b01);
      base = n_rises;
      drive(0, 32'hDEADBEEF, 1'b0, wa);
      n = 0;
      while ((n_rises < base + 2 || tx_start) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("mid_rises", 32'(n_rises - base), 32'd2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_tx_start", {31'd0, tx_start}, 32'd0);
      check("mid_grant", {30'd0, grant}, 32'd0);
      check("mid_data", {24'd0, uart_data_out}, 32'd0);
      check("mid_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_queue", 32'(exp_byte_q.size()), 32'd0);
      push_word(2'b10, 32'h01020304);
      drive(1, 32'h01020304, 1'b1, wb);
      check("mid_req1_immediate", 32'(wb), 32'd0);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter of the debug unit between two word-wide requesters. Requester 0 is the pipeline/register dump path; requester 1 is the status/ack message path. Each accepted word is serialised into LEN_DATA-bit bytes, least-significant byte first, using the tx_start/tx_done handshake. Arbitration is round-robin at packet granularity, and a packet (a word sequence ending in last) is never interleaved with the other requester's words.

Parameters:
len, 32, width of a requester word
LEN_DATA, 8, UART byte width
NB_BYTES, len/LEN_DATA, bytes per word
NB_CNT, $clog2(NB_BYTES), byte counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a word
req0_data  in  len  requester 0 word
req0_last  in  1  word is the last of requester 0's packet
req0_ready  out  1  requester 0 word accepted this cycle (valid&ready)
req1_valid  in  1  requester 1 has a word
req1_data  in  len  requester 1 word
req1_last  in  1  word is the last of requester 1's packet
req1_ready  out  1  requester 1 word accepted this cycle
tx_done  in  1  UART byte finished (one-cycle pulse)
tx_start  out  1  UART transmit request, held until tx_done
uart_data_out  out  LEN_DATA  byte presented to the UART
grant  out  2  one-hot owner of the transmitter (00 = none)
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock, clk. reset is synchronous and active-high. On reset: state=IDLE, tx_start=0, uart_data_out=0, grant=00, busy=0, req*_ready=0, lock=0, rr_ptr=0 (requester 0 has priority), byte_cnt=0, shift register=0.
- Reset mid-transfer drops the in-flight word and clears the lock. No further tx_start is issued.
- States are IDLE, SEND and GAP.
- IDLE:
  - Arbitration is combinational. If lock=1, only the owner is eligible.
  - Otherwise, if both requesters are valid, the one selected by rr_ptr wins. If only one is valid, it wins.
  - The winner's req*_ready=1 in the same cycle as its valid, and the transfer occurs that cycle. The loser's ready=0.
  - On transfer: capture data into the shift register, capture last into last_q, set grant to the winner's one-hot, set byte_cnt=0, go to SEND.
  - ready is never 1 outside IDLE or during reset.
- SEND:
  - tx_start=1 and uart_data_out=shift[LEN_DATA-1:0], both registered. They are first valid the cycle after acceptance (latency 1).
  - tx_start and uart_data_out stay stable until tx_done. On tx_done: tx_start=0 and go to GAP.
- GAP (one cycle, tx_start=0, gives the UART a fresh rising edge):
  - If byte_cnt < NB_BYTES-1: byte_cnt+1, shift right by LEN_DATA, return to SEND.
  - Otherwise the word is complete. If last_q=1: lock=0, grant=00, rr_ptr points to the other requester. If last_q=0: lock=1 and grant is kept. Then go to IDLE.
- While locked in IDLE with the owner's valid=0, the scheduler waits. The other requester stays blocked even if it is valid.
- tx_done outside SEND is ignored.
- Any change on req*_data/last while not accepted has no effect.
- Per-byte cost is 2 cycles (SEND at least 1 cycle plus GAP) plus the UART time. Minimum word-to-word gap is 1 IDLE cycle.
- byte_cnt wraps only via the reload in IDLE and never exceeds NB_BYTES-1.

Test Plan:
- Reset, then req0 sends 0x11223344 with last=1 and tx_done pulses 3 cycles after each tx_start rise -> uart_data_out=44,33,22,11 in order, exactly 4 tx_start rising edges, req0_ready high for 1 cycle, grant 01 then 00, rr_ptr=1.
- Both valid in the same cycle after reset (req0=0xAAAAAAAA last=1, req1=0x55555555 last=1) -> req0 served first, then req1. Next simultaneous request serves req1 first only if rr_ptr=0 again; otherwise alternation is verified over 4 packets.
- req0 packet of 3 words (last on word 3) while req1 is held valid throughout -> all 12 req0 bytes precede any req1 byte, and req1_ready stays 0 until req0's last word completes.
- Lock stall: req0 word 1 (last=0) sent, then req0_valid=0 for 20 cycles while req1 is valid -> no tx_start, grant stays 01, busy=0. Word 2 (last=1) then proceeds.
- Spurious tx_done pulses during IDLE and GAP -> no state change and no extra bytes emitted.
- Reset asserted after the 2nd byte of a word -> next cycle tx_start=0, grant=00, uart_data_out=0, lock=0. A subsequent req1 word is granted immediately.
